// File: rtl/i2c_bus_monitor.sv
// Passive I2C bus monitor: filtered SCL/SDA, START/STOP detection,
// byte/ACK decode, per-transaction byte count and protocol error flags.
module i2c_bus_monitor #(
   parameter int FILTER_LEN = 3,
   parameter int TIMEOUT_W  = 16,
   parameter int CNT_W      = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 scl_i,
   input  logic                 sda_i,
   input  logic                 enable,
   input  logic [TIMEOUT_W-1:0] timeout_limit,
   output logic                 start_o,
   output logic                 rstart_o,
   output logic                 stop_o,
   output logic                 byte_valid_o,
   output logic [7:0]           byte_o,
   output logic                 ack_o,
   output logic                 is_addr_o,
   output logic [CNT_W-1:0]     byte_cnt_o,
   output logic                 busy_o,
   output logic                 err_o,
   output logic [1:0]           err_code_o
);
   localparam int FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [FW-1:0] FMAX = FW'(FILTER_LEN - 1);

   typedef enum logic [1:0] {IDLE, DATA, ACKB} state_t;

   // bit 0 = SCL, bit 1 = SDA
   logic [1:0]    s1_q, s2_q, f_q, p_q;
   logic [FW-1:0] fc_q [2];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         s1_q     <= 2'b11;
         s2_q     <= 2'b11;
         f_q      <= 2'b11;
         p_q      <= 2'b11;
         fc_q[0]  <= '0;
         fc_q[1]  <= '0;
      end else begin
         s1_q <= {sda_i, scl_i};
         s2_q <= s1_q;
         p_q  <= f_q;
         for (int i = 0; i < 2; i++) begin
            if (s2_q[i] == f_q[i]) begin
               fc_q[i] <= '0;
            end else if (fc_q[i] == FMAX) begin
               f_q[i]  <= s2_q[i];
               fc_q[i] <= '0;
            end else begin
               fc_q[i] <= fc_q[i] + 1'b1;
            end
         end
      end
   end

   logic start_c, stop_c, rise_c, partial;
   assign start_c = p_q[0] & f_q[0] & p_q[1] & ~f_q[1];
   assign stop_c  = p_q[0] & f_q[0] & ~p_q[1] & f_q[1];
   assign rise_c  = ~p_q[0] & f_q[0];

   state_t                 state_q, state_d;
   logic [3:0]             bit_q, bit_d;
   logic [7:0]             sh_q, sh_d, byte_q, byte_d;
   logic                   ack_q, ack_d, ia_q, ia_d, af_q, af_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic [TIMEOUT_W-1:0]   to_q, to_d, to_inc;
   logic [1:0]             code_q, code_d;
   logic                   start_q, start_d, rstart_q, rstart_d;
   logic                   stop_q, stop_d, bv_q, bv_d;
   logic                   err_q, err_d, busy_q, busy_d;

   // The SCL rise that sets up a START/STOP is counted as a bit, so a
   // byte is partial only once a further bit has been clocked.
   assign partial = (state_q == ACKB) || (state_q == DATA && bit_q > 4'd1);
   assign to_inc  = (to_q == '1) ? to_q : to_q + 1'b1;

   always_comb begin
      state_d  = state_q;
      bit_d    = bit_q;
      sh_d     = sh_q;
      byte_d   = byte_q;
      ack_d    = ack_q;
      ia_d     = ia_q;
      af_d     = af_q;
      cnt_d    = cnt_q;
      to_d     = to_q;
      code_d   = code_q;
      start_d  = 1'b0;
      rstart_d = 1'b0;
      stop_d   = 1'b0;
      bv_d     = 1'b0;
      err_d    = 1'b0;
      if (!enable) begin
         state_d = IDLE;
         bit_d   = '0;
         cnt_d   = '0;
         to_d    = '0;
      end else if (start_c) begin
         if (state_q == IDLE) start_d = 1'b1;
         else rstart_d = 1'b1;
         if (partial) begin
            err_d  = 1'b1;
            code_d = 2'b01;
         end
         state_d = DATA;
         bit_d   = '0;
         cnt_d   = '0;
         af_d    = 1'b1;
         to_d    = '0;
      end else if (stop_c) begin
         stop_d = 1'b1;
         if (partial) begin
            err_d  = 1'b1;
            code_d = 2'b01;
         end
         state_d = IDLE;
         bit_d   = '0;
         to_d    = '0;
      end else if (state_q != IDLE) begin
         if (!f_q[0]) begin
            to_d = to_inc;
            if (timeout_limit != '0 && to_inc == timeout_limit) begin
               err_d   = 1'b1;
               code_d  = 2'b10;
               state_d = IDLE;
               bit_d   = '0;
               to_d    = '0;
            end
         end else begin
            to_d = '0;
            if (rise_c) begin
               unique case (state_q)
                  DATA: begin
                     sh_d  = {sh_q[6:0], f_q[1]};
                     bit_d = bit_q + 4'd1;
                     if (bit_q == 4'd7) state_d = ACKB;
                  end
                  ACKB: begin
                     byte_d  = sh_q;
                     ack_d   = f_q[1];
                     ia_d    = af_q;
                     af_d    = 1'b0;
                     cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + 1'b1;
                     bv_d    = 1'b1;
                     bit_d   = '0;
                     state_d = DATA;
                  end
                  default: ;
               endcase
            end
         end
      end
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= IDLE;
         bit_q    <= '0;
         sh_q     <= '0;
         byte_q   <= '0;
         ack_q    <= 1'b1;
         ia_q     <= 1'b0;
         af_q     <= 1'b0;
         cnt_q    <= '0;
         to_q     <= '0;
         code_q   <= 2'b00;
         start_q  <= 1'b0;
         rstart_q <= 1'b0;
         stop_q   <= 1'b0;
         bv_q     <= 1'b0;
         err_q    <= 1'b0;
         busy_q   <= 1'b0;
      end else begin
         state_q  <= state_d;
         bit_q    <= bit_d;
         sh_q     <= sh_d;
         byte_q   <= byte_d;
         ack_q    <= ack_d;
         ia_q     <= ia_d;
         af_q     <= af_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         code_q   <= code_d;
         start_q  <= start_d;
         rstart_q <= rstart_d;
         stop_q   <= stop_d;
         bv_q     <= bv_d;
         err_q    <= err_d;
         busy_q   <= busy_d;
      end
   end

   assign start_o      = start_q;
   assign rstart_o     = rstart_q;
   assign stop_o       = stop_q;
   assign byte_valid_o = bv_q;
   assign byte_o       = byte_q;
   assign ack_o        = ack_q;
   assign is_addr_o    = ia_q;
   assign byte_cnt_o   = cnt_q;
   assign busy_o       = busy_q;
   assign err_o        = err_q;
   assign err_code_o   = code_q;

endmodule
